bin2bcd_seq: RTL



---
 rtl/bin2bcd_seq.sv | 135 +++++++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one input bit per clock, start/busy/done handshake.
// Optional macro GRAY_OUT_EN adds a registered Gray-code copy of the converted value.
module bin2bcd_seq #(
   parameter int N      = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [N-1:0]          bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  ovf
`ifdef GRAY_OUT_EN
   ,
   output logic [N-1:0]          gray
`endif
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(N + 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t          state_q, state_d;
   logic [N-1:0]    sh_q, sh_d;
   logic [BW-1:0]   acc_q, acc_d, acc_adj;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            ovfacc_q, ovfacc_d;
   logic            done_q, done_d;
   logic [BW-1:0]   bcd_q, bcd_d;
   logic            ovf_q, ovf_d;
`ifdef GRAY_OUT_EN
   logic [N-1:0]    cap_q, cap_d;
   logic [N-1:0]    gray_q, gray_d;
`endif

   // Add 3 to every digit >= 5 so the following left shift carries correctly into the next digit.
   function automatic logic [BW-1:0] adjust(input logic [BW-1:0] a);
      logic [BW-1:0] r;
      r = a;
      for (int d = 0; d < DIGITS; d++) begin
         if (a[4*d +: 4] >= 4'd5)
            r[4*d +: 4] = a[4*d +: 4] + 4'd3;
      end
      return r;
   endfunction

   always_comb begin
      acc_adj  = adjust(acc_q);
      state_d  = state_q;
      sh_d     = sh_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      ovfacc_d = ovfacc_q;
      done_d   = 1'b0;
      bcd_d    = bcd_q;
      ovf_d    = ovf_q;
`ifdef GRAY_OUT_EN
      cap_d    = cap_q;
      gray_d   = gray_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               sh_d     = bin;
               acc_d    = '0;
               ovfacc_d = 1'b0;
               cnt_d    = CW'(N);
               state_d  = SHIFT;
`ifdef GRAY_OUT_EN
               cap_d    = bin;
`endif
            end
         end
         SHIFT: begin
            // The bit leaving the top digit means the value needs more than DIGITS digits.
            acc_d    = {acc_adj[BW-2:0], sh_q[N-1]};
            sh_d     = {sh_q[N-2:0], 1'b0};
            ovfacc_d = ovfacc_q | acc_adj[BW-1];
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               bcd_d   = {acc_adj[BW-2:0], sh_q[N-1]};
               ovf_d   = ovfacc_q | acc_adj[BW-1];
               done_d  = 1'b1;
               state_d = IDLE;
`ifdef GRAY_OUT_EN
               gray_d  = cap_q ^ (cap_q >> 1);
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         sh_q     <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         ovfacc_q <= 1'b0;
         done_q   <= 1'b0;
         bcd_q    <= '0;
         ovf_q    <= 1'b0;
`ifdef GRAY_OUT_EN
         cap_q    <= '0;
         gray_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         sh_q     <= sh_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         ovfacc_q <= ovfacc_d;
         done_q   <= done_d;
         bcd_q    <= bcd_d;
         ovf_q    <= ovf_d;
`ifdef GRAY_OUT_EN
         cap_q    <= cap_d;
         gray_q   <= gray_d;
`endif
      end
   end

   assign busy = (state_q == SHIFT);
   assign done = done_q;
   assign bcd  = bcd_q;
   assign ovf  = ovf_q;
`ifdef GRAY_OUT_EN
   assign gray = gray_q;
`endif

endmodule
